// File: rtl/corr_pkg.sv
// Shared types and record layout for the corr_capture response-capture block.
package corr_pkg;

  localparam int TOG_W    = 8;
  localparam int SETTLE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_A = 3'd1,
    S_ARMED  = 3'd2,
    S_WAIT_B = 3'd3,
    S_PUSH   = 3'd4
  } corr_state_e;

  // Width needed to hold a popcount of 0..out_size.
  function automatic int cw_of(input int out_size);
    return $clog2(out_size + 1);
  endfunction

  // Record layout, LSB first: toggles, hd, hw_b, hw_a, sim_id.
  function automatic int hd_lsb(input int cw);
    return TOG_W;
  endfunction

  function automatic int hwb_lsb(input int cw);
    return TOG_W + cw;
  endfunction

  function automatic int hwa_lsb(input int cw);
    return TOG_W + 2 * cw;
  endfunction

  function automatic int id_lsb(input int cw);
    return TOG_W + 3 * cw;
  endfunction

  function automatic int rec_w(input int idx_w, input int cw);
    return idx_w + 3 * cw + TOG_W;
  endfunction

endpackage

// File: rtl/corr_rec_if.sv
// Record drain port of corr_capture: valid/ready plus the record fields.
interface corr_rec_if #(
  parameter int IDX_W = 8,
  parameter int CW    = 4
);
  import corr_pkg::*;

  logic             rec_valid;
  logic             rec_ready;
  logic [IDX_W-1:0] rec_sim_id;
  logic [CW-1:0]    rec_hw_a;
  logic [CW-1:0]    rec_hw_b;
  logic [CW-1:0]    rec_hd;
  logic [TOG_W-1:0] rec_toggles;

  modport master (
    output rec_valid, rec_sim_id, rec_hw_a, rec_hw_b, rec_hd, rec_toggles,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_sim_id, rec_hw_a, rec_hw_b, rec_hd, rec_toggles,
    output rec_ready
  );
endinterface

// File: rtl/corr_popcount.sv
// Combinational population count of a W-bit vector.
module corr_popcount
  import corr_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = cw_of(W)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    // NOTE: combinational logic uses blocking assignments and gives every output a default first, so no latch is inferred.
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(din[i]);
    end
  end

endmodule

// File: rtl/corr_capture.sv
// Captures DUT output after vectors A and B, logs popcounts/distance into a FWFT FIFO.
// Optional toggle counting is enabled with `define CORR_TOGGLE_EN.
module corr_capture
  import corr_pkg::*;
#(
  parameter int OUT_SIZE   = 8,
  parameter int IDX_W      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OUT_SIZE-1:0] dut_out,
  input  logic                begin_sim,
  input  logic                end_sim,
  corr_rec_if.master          rec,
  output logic                busy,
  output logic                proto_err,
  output logic                overflow
);

  localparam int CW = cw_of(OUT_SIZE);
  localparam int RW = rec_w(IDX_W, CW);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CYC);

  // Reset asserts asynchronously and releases two clocks after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop sees pre-edge values.
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  corr_state_e           state, state_n;
  logic [SETTLE_W-1:0]   cnt, cnt_n;
  logic [OUT_SIZE-1:0]   reg_a, reg_b;
  logic [IDX_W-1:0]      sim_id;
  logic                  samp_a, samp_b, push, win_start, err_set;
  logic                  beg, endv;

  assign beg  = begin_sim & ~end_sim;
  assign endv = end_sim & ~begin_sim;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    samp_a    = 1'b0;
    samp_b    = 1'b0;
    push      = 1'b0;
    win_start = 1'b0;
    err_set   = begin_sim & end_sim;
    unique case (state)
      S_IDLE: begin
        if (beg)       win_start = 1'b1;
        else if (endv) err_set   = 1'b1;
      end
      S_WAIT_A: begin
        if (beg) begin
          err_set   = 1'b1;
          win_start = 1'b1;
        end else begin
          if (endv) err_set = 1'b1;
          if (cnt == '0) begin
            samp_a  = 1'b1;
            state_n = S_ARMED;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (beg) begin
          err_set   = 1'b1;
          win_start = 1'b1;
        end else if (endv) begin
          state_n = S_WAIT_B;
          cnt_n   = SETTLE_LD;
        end
      end
      S_WAIT_B: begin
        if (beg) begin
          err_set   = 1'b1;
          win_start = 1'b1;
        end else if (cnt == '0) begin
          samp_b  = 1'b1;
          state_n = S_PUSH;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_n = S_IDLE;
        if (beg)       win_start = 1'b1;
        else if (endv) err_set   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    if (win_start) begin
      state_n = S_WAIT_A;
      cnt_n   = SETTLE_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      sim_id    <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (samp_a)  reg_a     <= dut_out;
      if (samp_b)  reg_b     <= dut_out;
      if (push)    sim_id    <= sim_id + 1'b1;
      if (err_set) proto_err <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  logic [CW-1:0] hw_a, hw_b, hd;

  corr_popcount #(.W(OUT_SIZE), .CW(CW)) u_pc_a  (.din(reg_a),         .cnt(hw_a));
  corr_popcount #(.W(OUT_SIZE), .CW(CW)) u_pc_b  (.din(reg_b),         .cnt(hw_b));
  corr_popcount #(.W(OUT_SIZE), .CW(CW)) u_pc_hd (.din(reg_a ^ reg_b), .cnt(hd));

  logic [TOG_W-1:0] tog_val;

`ifdef CORR_TOGGLE_EN
  logic [OUT_SIZE-1:0] prev_out;
  logic [TOG_W-1:0]    tog_cnt;
  logic                changed;

  assign changed = (dut_out != prev_out);

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      prev_out <= '0;
      tog_cnt  <= '0;
    end else begin
      prev_out <= dut_out;
      if (win_start)
        tog_cnt <= TOG_W'(changed);
      else if ((state inside {S_WAIT_A, S_ARMED, S_WAIT_B}) && changed && (tog_cnt != '1))
        tog_cnt <= tog_cnt + 1'b1;
    end
  end
  assign tog_val = tog_cnt;
`else
  assign tog_val = '0;
`endif

  // Record FIFO: extra pointer bit distinguishes full from empty.
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [RW-1:0] rec_word, head, hold;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, wr_en, drop;

  assign rec_word = {sim_id, hw_a, hw_b, hd, tog_val};
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && rec.rec_ready;
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;

  always_ff @(posedge clk) begin
    // NOTE: storage array is not reset; only pointers and the hold register carry reset state.
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rec_word;
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr[AW-1:0]];
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // When empty, fields keep showing the most recently popped record.
  assign head            = empty ? hold : mem[rd_ptr[AW-1:0]];
  assign rec.rec_valid   = !empty;
  assign rec.rec_sim_id  = head[id_lsb(CW)  +: IDX_W];
  assign rec.rec_hw_a    = head[hwa_lsb(CW) +: CW];
  assign rec.rec_hw_b    = head[hwb_lsb(CW) +: CW];
  assign rec.rec_hd      = head[hd_lsb(CW)  +: CW];
  assign rec.rec_toggles = head[0 +: TOG_W];

endmodule
